// File: rtl/register_bank.sv
// Two-read/one-write register bank with write enable, optional hardwired
// zero register, same-cycle write-to-read bypass, and a synchronous reset
// that clears the array one entry per clock while Busy is high.
module register_bank #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_REGS = 32,
  parameter int ZERO_REG = 1
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Reg_Write,
  input  logic [ADDR_W-1:0] Write_Register,
  input  logic [DATA_W-1:0] Write_Data,
  input  logic [ADDR_W-1:0] Read_Register1,
  input  logic [ADDR_W-1:0] Read_Register2,
  output logic [DATA_W-1:0] Read_Data1,
  output logic [DATA_W-1:0] Read_Data2,
  output logic              Busy
);

  // Array index width; the sweep counter is one bit wider than an address
  // so NUM_REGS == 2**ADDR_W can be represented without wrapping.
  localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [ADDR_W:0] NREGS_C = (ADDR_W+1)'(NUM_REGS);
  localparam logic [ADDR_W:0] LAST_C  = (ADDR_W+1)'(NUM_REGS - 1);
  localparam logic [ADDR_W:0] ONE_C   = (ADDR_W+1)'(1);

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W:0]   idx_q, idx_d;
  logic [DATA_W-1:0] mem_q [NUM_REGS];

  logic              wr_ok_s;
  logic              mem_we_s;
  logic [IDX_W-1:0]  mem_waddr_s;
  logic [DATA_W-1:0] mem_wdata_s;

  // An address is readable/writable if implemented and not the hardwired zero.
  function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
    return ({1'b0, a} < NREGS_C) && !((ZERO_REG != 0) && (a == '0));
  endfunction

  // Resolve one read port: busy, then unmapped/zero, then bypass, then array.
  function automatic logic [DATA_W-1:0] read_port(
    input logic              busy,
    input logic [ADDR_W-1:0] a,
    input logic              wr_ok,
    input logic [ADDR_W-1:0] wa,
    input logic [DATA_W-1:0] wd,
    input logic [DATA_W-1:0] stored
  );
    logic [DATA_W-1:0] r;
    if (busy) begin
      r = '0;
    end else if (!addr_ok(a)) begin
      r = '0;
    end else if (wr_ok && (wa == a)) begin
      r = wd;
    end else begin
      r = stored;
    end
    return r;
  endfunction

  // State and sweep-index registers; reset restarts the sweep from entry 0.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= CLEAR;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Next-state logic: advance the sweep, leave CLEAR after the last entry.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      CLEAR: begin
        idx_d = idx_q + ONE_C;
        if (idx_q == LAST_C) begin
          state_d = RUN;
        end else begin
          state_d = CLEAR;
        end
      end
      RUN: begin
        state_d = RUN;
      end
      default: begin
        state_d = CLEAR;
        idx_d   = '0;
      end
    endcase
  end

  // Array write port: sweep clears in CLEAR, qualified user write in RUN.
  always_comb begin
    wr_ok_s     = Reg_Write && addr_ok(Write_Register) && (state_q == RUN);
    mem_we_s    = 1'b0;
    mem_waddr_s = '0;
    mem_wdata_s = '0;
    if (Reset) begin
      mem_we_s = 1'b0;
    end else if (state_q == CLEAR) begin
      mem_we_s    = 1'b1;
      mem_waddr_s = idx_q[IDX_W-1:0];
    end else if (wr_ok_s) begin
      mem_we_s    = 1'b1;
      mem_waddr_s = Write_Register[IDX_W-1:0];
      mem_wdata_s = Write_Data;
    end else begin
      mem_we_s = 1'b0;
    end
  end

  // Storage array update.
  always_ff @(posedge Clock) begin
    if (mem_we_s) begin
      mem_q[mem_waddr_s] <= mem_wdata_s;
    end
  end

  // Busy flag and both combinational read ports.
  always_comb begin
    Busy       = (state_q == CLEAR);
    Read_Data1 = read_port(Busy, Read_Register1, wr_ok_s, Write_Register,
                           Write_Data, mem_q[Read_Register1[IDX_W-1:0]]);
    Read_Data2 = read_port(Busy, Read_Register2, wr_ok_s, Write_Register,
                           Write_Data, mem_q[Read_Register2[IDX_W-1:0]]);
  end

endmodule

// File: tb/tb_register_bank.sv
// Scoreboard bench for register_bank: three configurations (default,
// ZERO_REG=0, NUM_REGS=16) share one stimulus stream; a reference model
// pushes expected outputs per cycle and a negedge monitor compares them.
module tb_register_bank;

  logic        Clock;
  logic        Reset;
  logic        Reg_Write;
  logic [4:0]  Write_Register;
  logic [31:0] Write_Data;
  logic [4:0]  Read_Register1;
  logic [4:0]  Read_Register2;

  logic [31:0] rd1_0, rd2_0, rd1_1, rd2_1, rd1_2, rd2_2;
  logic        busy_0, busy_1, busy_2;

  register_bank #(.DATA_W(32), .ADDR_W(5), .NUM_REGS(32), .ZERO_REG(1)) u_def (
    .Clock(Clock), .Reset(Reset), .Reg_Write(Reg_Write),
    .Write_Register(Write_Register), .Write_Data(Write_Data),
    .Read_Register1(Read_Register1), .Read_Register2(Read_Register2),
    .Read_Data1(rd1_0), .Read_Data2(rd2_0), .Busy(busy_0));

  register_bank #(.DATA_W(32), .ADDR_W(5), .NUM_REGS(32), .ZERO_REG(0)) u_nz (
    .Clock(Clock), .Reset(Reset), .Reg_Write(Reg_Write),
    .Write_Register(Write_Register), .Write_Data(Write_Data),
    .Read_Register1(Read_Register1), .Read_Register2(Read_Register2),
    .Read_Data1(rd1_1), .Read_Data2(rd2_1), .Busy(busy_1));

  register_bank #(.DATA_W(32), .ADDR_W(5), .NUM_REGS(16), .ZERO_REG(1)) u_16 (
    .Clock(Clock), .Reset(Reset), .Reg_Write(Reg_Write),
    .Write_Register(Write_Register), .Write_Data(Write_Data),
    .Read_Register1(Read_Register1), .Read_Register2(Read_Register2),
    .Read_Data1(rd1_2), .Read_Data2(rd2_2), .Busy(busy_2));

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  typedef struct packed {
    int              cyc;
    logic [2:0]      b;
    logic [2:0][31:0] r1;
    logic [2:0][31:0] r2;
  } exp_t;

  exp_t exp_q[$];

  int errors = 0;
  int checks = 0;
  int cycle  = 0;

  // Reference model state per configuration.
  int          cfg_n [3] = '{32, 32, 16};
  int          cfg_z [3] = '{1, 0, 1};
  logic [31:0] mem_m [3][32];
  int          busy_left [3];
  bit          model_valid = 1'b0;

  function automatic bit wr_valid(int c);
    return (busy_left[c] == 0) && Reg_Write && (int'(Write_Register) < cfg_n[c])
           && !(cfg_z[c] != 0 && Write_Register == 5'd0);
  endfunction

  function automatic logic [31:0] m_read(int c, logic [4:0] a);
    if (busy_left[c] > 0) return 32'd0;
    if (int'(a) >= cfg_n[c]) return 32'd0;
    if (cfg_z[c] != 0 && a == 5'd0) return 32'd0;
    if (wr_valid(c) && Write_Register == a) return Write_Data;
    return mem_m[c][a];
  endfunction

  // Apply the effect of one clock edge with the inputs currently driven.
  function automatic void model_edge();
    for (int c = 0; c < 3; c++) begin
      if (Reset) begin
        busy_left[c] = cfg_n[c];
      end else if (busy_left[c] > 0) begin
        busy_left[c] = busy_left[c] - 1;
        if (busy_left[c] == 0) begin
          for (int k = 0; k < 32; k++) mem_m[c][k] = 32'd0;
        end
      end else if (wr_valid(c)) begin
        mem_m[c][Write_Register] = Write_Data;
      end
    end
    if (Reset) model_valid = 1'b1;
  endfunction

  function automatic void check(string nm, logic [31:0] got, logic [31:0] exp, int cyc);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d got=%h expected=%h", nm, cyc, got, exp);
    end
  endfunction

  // Monitor: compare DUT outputs against the oldest queued expectation.
  always @(negedge Clock) begin
    exp_t e;
    logic [2:0]       gb;
    logic [2:0][31:0] g1, g2;
    if (exp_q.size() > 0) begin
      e  = exp_q.pop_front();
      gb = {busy_2, busy_1, busy_0};
      g1 = {rd1_2, rd1_1, rd1_0};
      g2 = {rd2_2, rd2_1, rd2_0};
      for (int c = 0; c < 3; c++) begin
        check($sformatf("cfg%0d_busy", c), {31'd0, gb[c]}, {31'd0, e.b[c]}, e.cyc);
        check($sformatf("cfg%0d_rd1", c), g1[c], e.r1[c], e.cyc);
        check($sformatf("cfg%0d_rd2", c), g2[c], e.r2[c], e.cyc);
      end
    end
  end

  // Drive one cycle of inputs, queue the expected outputs, then clock it.
  task automatic step(input logic rst, input logic we, input logic [4:0] wa,
                      input logic [31:0] wd, input logic [4:0] ra1, input logic [4:0] ra2);
    exp_t e;
    Reset          = rst;
    Reg_Write      = we;
    Write_Register = wa;
    Write_Data     = wd;
    Read_Register1 = ra1;
    Read_Register2 = ra2;
    if (model_valid) begin
      e.cyc = cycle;
      for (int c = 0; c < 3; c++) begin
        e.b[c]  = (busy_left[c] > 0);
        e.r1[c] = m_read(c, ra1);
        e.r2[c] = m_read(c, ra2);
      end
      exp_q.push_back(e);
    end
    @(posedge Clock);
    model_edge();
    cycle++;
    #1;
  endtask

  function automatic logic [4:0] rand_addr();
    if ($urandom_range(0, 1) == 0) return 5'($urandom_range(0, 7));
    return 5'($urandom_range(0, 31));
  endfunction

  initial begin
    for (int c = 0; c < 3; c++) begin
      busy_left[c] = 0;
      for (int k = 0; k < 32; k++) mem_m[c][k] = 32'd0;
    end

    // Reset for two cycles, then let the sweep run and read every register.
    step(1'b1, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
    step(1'b1, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
    for (int i = 0; i < 34; i++) step(1'b0, 1'b0, 5'd0, 32'd0, 5'(i), 5'(31 - i));
    for (int i = 0; i < 32; i++) step(1'b0, 1'b0, 5'd0, 32'd0, 5'(i), 5'(31 - i));

    // Plain write and readback, with a neighbouring register staying 0.
    step(1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd6);
    step(1'b0, 1'b0, 5'd0, 32'd0, 5'd5, 5'd6);

    // Same-cycle bypass on both ports.
    step(1'b0, 1'b1, 5'd7, 32'h12345678, 5'd7, 5'd7);
    step(1'b0, 1'b0, 5'd0, 32'd0, 5'd7, 5'd7);

    // Register 0 write: ignored when hardwired, stored otherwise.
    step(1'b0, 1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0);
    step(1'b0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);

    // Unimplemented register in the 16-entry bank.
    step(1'b0, 1'b1, 5'd20, 32'h00000001, 5'd20, 5'd20);
    step(1'b0, 1'b0, 5'd0, 32'd0, 5'd20, 5'd20);

    // Reset mid-sweep discards data; a write during Busy is dropped.
    step(1'b0, 1'b1, 5'd3, 32'hA5A5A5A5, 5'd3, 5'd3);
    step(1'b1, 1'b0, 5'd0, 32'd0, 5'd3, 5'd3);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 5'd0, 32'd0, 5'd3, 5'd9);
    step(1'b1, 1'b0, 5'd0, 32'd0, 5'd3, 5'd9);
    step(1'b0, 1'b1, 5'd9, 32'h11111111, 5'd9, 5'd3);
    for (int i = 0; i < 33; i++) step(1'b0, 1'b0, 5'd0, 32'd0, 5'd3, 5'd9);
    step(1'b0, 1'b0, 5'd0, 32'd0, 5'd3, 5'd9);

    // Randomised traffic with occasional resets.
    for (int i = 0; i < 2500; i++) begin
      step(($urandom_range(0, 299) == 0) ? 1'b1 : 1'b0,
           1'($urandom_range(0, 1)), rand_addr(), $urandom(),
           rand_addr(), rand_addr());
    end
    step(1'b0, 1'b0, 5'd0, 32'd0, 5'd1, 5'd2);

    @(negedge Clock);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
